eth_frame_builder: RTL and testbench

- Upstream neighbour of the transmit stage (fifo_data_buffer -> bitorder -> RMII).
- Takes a raw payload byte stream and emits a complete Ethernet II frame as a byte stream on axiov/axiod: preamble, SFD, fixed MAC header, payload, zero pad, CRC-32 FCS.
- Byte rate is paced to RMII (one byte per BYTE_PERIOD clocks), so the downstream buffer never overflows.
- Inter-frame gap is enforced between frames.

---
 rtl/eth_frame_builder.sv | 184 ++++++++++++++++++
 tb/tb_eth_frame_builder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_builder.sv
// Ethernet II framer: preamble/SFD, fixed MAC header, payload, zero pad, CRC-32 FCS, then IFG.
// One byte per BYTE_PERIOD clocks; payload byte pulled one cycle before its slot, never stalled.
module eth_frame_builder #(
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC     = 48'h00_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          BYTE_PERIOD = 4,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          IFG_BYTES   = 12
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       axiov,
  output logic [7:0] axiod,
  output logic       busy,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_UND, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam int              TW     = $clog2(BYTE_PERIOD);
  localparam logic [TW-1:0]   T_LAST = TW'(BYTE_PERIOD - 1);
  localparam int              PW     = $clog2(MAX_PAYLOAD + 1);
  localparam logic [PW-1:0]   P_MIN  = PW'(MIN_PAYLOAD);
  localparam logic [PW-1:0]   P_LAST = PW'(MAX_PAYLOAD - 1);
  localparam logic [7:0]      I_LAST = 8'(IFG_BYTES - 1);
  localparam logic [111:0]    HDR    = {DST_MAC, SRC_MAC, ETHERTYPE};

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            last_q, last_d;
  logic [31:0]     crc_q, crc_d;
  logic            axiov_q, axiov_d;
  logic [7:0]      axiod_q, axiod_d;
  logic            err_q, err_d;
  logic            slot_end, start, new_slot, take, accept;
  logic [7:0]      byte_d;
  logic [31:0]     fcs;

  assign slot_end = (state_q != S_IDLE) && (timer_q == T_LAST);
  assign start    = (state_q == S_IDLE) && s_valid;
  assign new_slot = slot_end || start;
  // Payload is pulled only at the end of the slot preceding a payload slot.
  assign take     = slot_end && (((state_q == S_HDR) && (cnt_q == 8'd13)) ||
                                 ((state_q == S_PAY) && !last_q));
  assign accept   = take && s_valid;
  assign fcs      = ~crc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      last_q  <= 1'b0;
      crc_q   <= 32'hFFFF_FFFF;
      axiov_q <= 1'b0;
      axiod_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      last_q  <= last_d;
      crc_q   <= crc_d;
      axiov_q <= axiov_d;
      axiod_q <= axiod_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    last_d  = last_q;
    if (state_q == S_IDLE) begin
      timer_d = '0;
      if (s_valid) begin
        state_d = S_PRE;
        cnt_d   = '0;
        pcnt_d  = '0;
        last_d  = 1'b0;
      end
    end else begin
      timer_d = slot_end ? '0 : timer_q + TW'(1);
      if (slot_end) begin
        unique case (state_q)
          S_PRE: begin
            if (cnt_q == 8'd6) begin
              state_d = S_SFD;
              cnt_d   = '0;
            end else cnt_d = cnt_q + 8'd1;
          end
          S_SFD: begin
            state_d = S_HDR;
            cnt_d   = '0;
          end
          S_HDR: begin
            if (cnt_q == 8'd13) state_d = s_valid ? S_PAY : S_UND;
            else                cnt_d   = cnt_q + 8'd1;
          end
          S_PAY, S_UND, S_PAD: begin
            if ((state_q == S_PAY) && !last_q) begin
              state_d = s_valid ? S_PAY : S_UND;
            end else if (pcnt_q < P_MIN) begin
              state_d = S_PAD;
              pcnt_d  = pcnt_q + PW'(1);
            end else begin
              state_d = S_FCS;
              cnt_d   = '0;
            end
          end
          S_FCS: begin
            if (cnt_q == 8'd3) begin
              state_d = S_IFG;
              cnt_d   = '0;
            end else cnt_d = cnt_q + 8'd1;
          end
          S_IFG: begin
            if (cnt_q == I_LAST) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else cnt_d = cnt_q + 8'd1;
          end
          default: state_d = S_IDLE;
        endcase
        if (accept) begin
          pcnt_d = pcnt_q + PW'(1);
          last_d = s_last || (pcnt_q == P_LAST);
        end
      end
    end
  end

  always_comb begin
    axiov_d = 1'b0;
    axiod_d = axiod_q;
    crc_d   = crc_q;
    err_d   = 1'b0;
    byte_d  = 8'h00;
    if (new_slot) begin
      unique case (state_d)
        S_PRE:   byte_d = 8'h55;
        S_SFD:   byte_d = 8'hD5;
        S_HDR:   byte_d = HDR[8*(13-int'(cnt_d)) +: 8];
        S_PAY:   byte_d = s_data;
        S_FCS:   byte_d = fcs[8*int'(cnt_d[1:0]) +: 8];
        default: byte_d = 8'h00;
      endcase
      axiov_d = state_d inside {S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCS};
      if (axiov_d) axiod_d = byte_d;
      if (state_d == S_PRE)                        crc_d = 32'hFFFF_FFFF;
      else if (state_d inside {S_HDR, S_PAY, S_PAD}) crc_d = crc_upd(crc_q, byte_d);
      // Underrun slot carries no byte; oversize flags the forced-last byte itself.
      err_d = (state_d == S_UND) || (accept && (pcnt_q == P_LAST) && !s_last);
    end
  end

  assign s_ready = take;
  assign axiov   = axiov_q;
  assign axiod   = axiod_q;
  assign busy    = (state_q != S_IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_eth_frame_builder.sv
// Directed bench for eth_frame_builder: frames captured byte by byte and compared to a reference framer.
module tb_eth_frame_builder;

  logic       clk;
  logic       rstn;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       axiov;
  logic [7:0] axiod;
  logic       busy;
  logic       err;

  eth_frame_builder dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .axiov(axiov), .axiod(axiod), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  logic [7:0] tx_q[$];
  bit         tx_l[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];
  bit         busy_h[$];
  int         err_t[$];
  bit         err_v[$];
  int         fs[$];
  int         rdy_n, rdy_bad;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    bit          fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic model(input int from, input int n);
    logic [31:0] c;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    repeat (6) exp_q.push_back(8'hFF);
    repeat (5) exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h88);
    exp_q.push_back(8'hB5);
    for (int i = 0; i < n; i++) exp_q.push_back(tx_q[from+i]);
    for (int i = n; i < 46; i++) exp_q.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < exp_q.size(); i++) c = ref_crc(c, exp_q[i]);
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endtask

  task automatic load(input int n, input int seed, input bit with_last);
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(8'((i * 7 + seed) & 255));
      tx_l.push_back(with_last && (i == n - 1));
    end
  endtask

  task automatic run(input int max_cyc);
    int idx, cyc;
    bit acc, done;
    rx_q.delete(); rx_t.delete(); busy_h.delete(); err_t.delete(); err_v.delete();
    rdy_n = 0; rdy_bad = 0; idx = 0; cyc = 0; acc = 0; done = 0;
    while (!done && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (acc && !axiov) rdy_bad++;
      if (axiov) begin
        rx_q.push_back(axiod);
        rx_t.push_back(cyc);
      end
      busy_h.push_back(busy);
      if (err) begin
        err_t.push_back(cyc);
        err_v.push_back(axiov);
      end
      if (acc) idx++;
      if (idx < tx_q.size()) begin
        s_valid = 1'b1; s_data = tx_q[idx]; s_last = tx_l[idx];
      end else begin
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      end
      if (s_ready) rdy_n++;
      acc  = s_ready && s_valid;
      done = (idx >= tx_q.size()) && !busy && (rx_q.size() > 0);
    end
    check("run finished within cycle budget", 32'(done), 1);
    fs.delete();
    for (int i = 0; i < rx_q.size(); i++)
      if (i == 0 || (rx_t[i] - rx_t[i-1]) > 20) fs.push_back(i);
  endtask

  function automatic int flen(input int k);
    return (k + 1 < fs.size()) ? fs[k+1] - fs[k] : rx_q.size() - fs[k];
  endfunction

  task automatic cmp_frame(input string tag, input int at);
    int mism;
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (at + i >= rx_q.size() || rx_q[at+i] !== exp_q[i]) mism++;
    check({tag, " bytes differing from model"}, mism, 0);
  endtask

  task automatic resid(input string tag, input int at, input int len);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = at + 8; i < at + len && i < rx_q.size(); i++) c = ref_crc(c, rx_q[i]);
    check({tag, " crc residue over frame"}, c, 32'hDEBB20E3);
  endtask

  task automatic spacing(input string tag, input int at, input int len);
    int bad;
    bad = 0;
    for (int i = at + 1; i < at + len && i < rx_t.size(); i++)
      if (rx_t[i] - rx_t[i-1] != 4) bad++;
    check({tag, " strobe gaps not 4"}, bad, 0);
  endtask

  task automatic ifg_busy(input string tag, input int last_t);
    int lows;
    lows = 0;
    for (int j = 1; j <= 51; j++)
      if (last_t + j - 1 >= busy_h.size() || !busy_h[last_t+j-1]) lows++;
    check({tag, " busy low cycles during ifg"}, lows, 0);
  endtask

  initial begin
    logic [31:0] c;
    int          seen;
    int          f1_last;
    rstn = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    #2;
    check("reset axiov", 32'(axiov), 0);
    check("reset axiod", 32'(axiod), 0);
    check("reset s_ready", 32'(s_ready), 0);
    check("reset busy", 32'(busy), 0);
    check("reset err", 32'(err), 0);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) c = ref_crc(c, 8'(8'h31 + i));
    check("reference crc of 123456789", ~c, 32'hCBF43926);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // single byte AB, fully padded
    tx_q.delete(); tx_l.delete();
    tx_q.push_back(8'hAB); tx_l.push_back(1'b1);
    run(1000);
    check("t1 strobe count", rx_q.size(), 72);
    check("t1 first strobe cycle", (rx_t.size() > 0) ? rx_t[0] : -1, 2);
    model(0, 1);
    cmp_frame("t1", 0);
    resid("t1", 0, 72);
    spacing("t1", 0, 72);
    check("t1 err pulses", err_t.size(), 0);
    check("t1 ready cycles", rdy_n, 1);
    if (rx_t.size() == 72) begin
      ifg_busy("t1", rx_t[71]);
      check("t1 busy after ifg", (rx_t[71] + 51 < busy_h.size()) ? 32'(busy_h[rx_t[71]+51]) : 32'hX, 0);
    end

    // 60-byte ramp, no pad
    tx_q.delete(); tx_l.delete();
    for (int i = 0; i < 60; i++) begin
      tx_q.push_back(8'(i)); tx_l.push_back(i == 59);
    end
    run(1000);
    check("t2 strobe count", rx_q.size(), 86);
    model(0, 60);
    cmp_frame("t2", 0);
    resid("t2", 0, 86);
    spacing("t2", 0, 86);
    check("t2 ready cycles", rdy_n, 60);
    check("t2 ready not followed by strobe", rdy_bad, 0);
    check("t2 err pulses", err_t.size(), 0);

    // underrun after 10 bytes
    tx_q.delete(); tx_l.delete();
    load(10, 5, 1'b0);
    run(1000);
    check("t3 strobe count", rx_q.size(), 72);
    model(0, 10);
    cmp_frame("t3", 0);
    resid("t3", 0, 72);
    check("t3 err pulses", err_t.size(), 1);
    if (err_t.size() == 1 && rx_t.size() == 72) begin
      check("t3 err without strobe", 32'(err_v[0]), 0);
      check("t3 err one slot after last payload", err_t[0], rx_t[31] + 4);
      check("t3 empty slot before pad", rx_t[32] - rx_t[31], 8);
    end

    // oversize: 1501 bytes, last only on the final one
    tx_q.delete(); tx_l.delete();
    load(1501, 3, 1'b1);
    run(10000);
    check("t4 frame count", fs.size(), 2);
    check("t4 err pulses", err_t.size(), 1);
    if (fs.size() == 2) begin
      check("t4 frame1 length", flen(0), 1526);
      check("t4 frame2 length", flen(1), 72);
      model(0, 1500);
      cmp_frame("t4 frame1", fs[0]);
      resid("t4 frame1", fs[0], 1526);
      model(1500, 1);
      cmp_frame("t4 frame2", fs[1]);
      check("t4 inter-frame gap", rx_t[fs[1]] - rx_t[fs[1]-1], 53);
      if (err_t.size() == 1) begin
        check("t4 err with strobe", 32'(err_v[0]), 1);
        check("t4 err on byte 1500", err_t[0], rx_t[fs[0] + 22 + 1499]);
      end
    end

    // reset while in header
    tx_q.delete(); tx_l.delete();
    tx_q.push_back(8'h3C); tx_l.push_back(1'b1);
    s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b1;
    seen = 0;
    for (int k = 0; k < 300 && seen < 10; k++) begin
      @(negedge clk);
      if (axiov) seen++;
    end
    check("t5 strobes before reset", seen, 10);
    #1 rstn = 1'b0;
    s_valid = 1'b0;
    #1;
    check("t5 async axiov", 32'(axiov), 0);
    check("t5 async busy", 32'(busy), 0);
    check("t5 async s_ready", 32'(s_ready), 0);
    @(negedge clk);
    rstn = 1'b1;
    run(1000);
    check("t5 fresh frame length", rx_q.size(), 72);
    model(0, 1);
    cmp_frame("t5", 0);
    resid("t5", 0, 72);

    // back-to-back frames of 2 and 3 bytes
    tx_q.delete(); tx_l.delete();
    load(2, 17, 1'b1);
    load(3, 90, 1'b1);
    run(2000);
    check("t6 frame count", fs.size(), 2);
    if (fs.size() == 2) begin
      check("t6 frame1 length", flen(0), 72);
      check("t6 frame2 length", flen(1), 72);
      model(0, 2);
      cmp_frame("t6 frame1", fs[0]);
      model(2, 3);
      cmp_frame("t6 frame2", fs[1]);
      f1_last = rx_t[fs[1]-1];
      check("t6 inter-frame gap", rx_t[fs[1]] - f1_last, 53);
      ifg_busy("t6", f1_last);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
